// File: rtl/edge_trigger_array_if.sv
// Event-line bundle for edge_trigger_array.
// master drives inputs/mode/clr, slave is the trigger block.
interface edge_trigger_array_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       in;
  logic [2*CH-1:0]     mode;
  logic                clr;
  logic [CH-1:0]       out;
  logic [CH-1:0]       flag;
  logic [CH*CNT_W-1:0] cnt;
  logic                any;

  modport master (
    output in, mode, clr,
    input  out, flag, cnt, any
  );

  modport slave (
    input  in, mode, clr,
    output out, flag, cnt, any
  );
endinterface

// File: rtl/edge_trigger_array.sv
// Multi-channel filtered edge trigger with pulse,
// sticky flag and saturating counter per channel.
module edge_trigger_array #(
  parameter int CH    = 4,
  parameter int FILT  = 2,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  edge_trigger_array_if.slave bus
);

  localparam int FC_W =
    (FILT > 0) ? $clog2(FILT + 1) : 1;
  localparam logic [FC_W-1:0] FC_MAX =
    FC_W'(FILT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0]    s;
  logic [CH-1:0]    f;
  logic [FC_W-1:0]  fc [CH];
  logic [CH-1:0]    acc;
  logic [CH-1:0]    hit;
  logic [CH-1:0]    out_q;
  logic [CH-1:0]    flag_q;
  logic [CNT_W-1:0] cnt_q [CH];

  // Accept when a differing level has persisted long enough;
  // qualify the accepted direction against the channel mode.
  always_comb begin
    acc = '0;
    hit = '0;
    for (int i = 0; i < CH; i++) begin
      acc[i] = (s[i] != f[i]) && (fc[i] == FC_MAX);
      hit[i] = acc[i] &&
        (f[i] ? bus.mode[2*i+1] : bus.mode[2*i]);
    end
  end

  // Input register and stability filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      f <= '0;
      for (int i = 0; i < CH; i++)
        fc[i] <= '0;
    end else begin
      s <= bus.in;
      for (int i = 0; i < CH; i++) begin
        if (s[i] == f[i]) begin
          fc[i] <= '0;
        end else if (acc[i]) begin
          f[i]  <= s[i];
          fc[i] <= '0;
        end else begin
          fc[i] <= fc[i] + FC_W'(1);
        end
      end
    end
  end

  // One-cycle event pulse per qualified accept.
  always_ff @(posedge clk) begin
    if (rst)
      out_q <= '0;
    else
      out_q <= hit;
  end

  // Sticky flags and saturating counters; an event
  // coinciding with clr survives as a fresh count of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= '0;
      for (int i = 0; i < CH; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (bus.clr) begin
          flag_q[i] <= hit[i];
          cnt_q[i]  <= hit[i] ? CNT_W'(1) : '0;
        end else if (hit[i]) begin
          flag_q[i] <= 1'b1;
          if (cnt_q[i] != CNT_MAX)
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.flag = flag_q;
  assign bus.any  = |out_q;

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign bus.cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_edge_trigger_array.sv
// Bench for edge_trigger_array: vector table, directed
// corner sequences and random traffic against a model.
module tb_edge_trigger_array;

  localparam int CH    = 4;
  localparam int FILT  = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk;
  logic rst;

  edge_trigger_array_if #(.CH(CH), .CNT_W(CNT_W)) bus ();
  edge_trigger_array_if #(.CH(CH), .CNT_W(CNT_W)) bus0 ();

  edge_trigger_array #(
    .CH(CH), .FILT(FILT), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  edge_trigger_array #(
    .CH(CH), .FILT(0), .CNT_W(CNT_W)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]  in;
    logic [7:0]  mode;
    logic        clr;
    logic [3:0]  out;
    logic [3:0]  flag;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [16];

  int nvec;
  int nerr;

  // Reference state: sample history per channel
  // (index 0 = newest registered sample), accepted level,
  // pulses, flags and counts.
  bit       m_hist [CH][FILT+1];
  bit       m_f    [CH];
  bit [3:0] m_out;
  bit [3:0] m_flag;
  int       m_cnt  [CH];

  task automatic push_hist(int ch, bit v);
    for (int j = FILT; j > 0; j--)
      m_hist[ch][j] = m_hist[ch][j-1];
    m_hist[ch][0] = v;
  endtask

  task automatic model_step();
    for (int ch = 0; ch < CH; ch++) begin
      if (rst) begin
        m_f[ch]    = 1'b0;
        m_cnt[ch]  = 0;
        m_out[ch]  = 1'b0;
        m_flag[ch] = 1'b0;
        push_hist(ch, 1'b0);
      end else begin
        bit acc;
        bit hit;
        acc = 1'b1;
        for (int j = 0; j <= FILT; j++)
          if (m_hist[ch][j] == m_f[ch]) acc = 1'b0;
        hit = acc && (m_f[ch] ? bus.mode[2*ch+1]
                              : bus.mode[2*ch]);
        if (acc) m_f[ch] = !m_f[ch];
        m_out[ch] = hit;
        if (bus.clr) begin
          m_flag[ch] = hit;
          m_cnt[ch]  = hit ? 1 : 0;
        end else if (hit) begin
          m_flag[ch] = 1'b1;
          if (m_cnt[ch] < CMAX) m_cnt[ch]++;
        end
        push_hist(ch, bus.in[ch]);
      end
    end
  endtask

  function automatic logic [15:0] m_cnt_vec();
    logic [15:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++)
      v[ch*4 +: 4] = 4'(m_cnt[ch]);
    return v;
  endfunction

  task automatic check_model();
    logic [15:0] ec;
    ec = m_cnt_vec();
    nvec++;
    if (bus.out !== m_out || bus.flag !== m_flag ||
        bus.cnt !== ec || bus.any !== (|m_out)) begin
      nerr++;
      $display("FAIL model t=%0t out=%h/%h flag=%h/%h cnt=%h/%h any=%b/%b (got/exp)",
        $time, bus.out, m_out, bus.flag, m_flag,
        bus.cnt, ec, bus.any, |m_out);
    end
  endtask

  task automatic check_exp(string nm, logic [3:0] eo,
                           logic [3:0] ef, logic [15:0] ec);
    nvec++;
    if (bus.out !== eo || bus.flag !== ef ||
        bus.cnt !== ec || bus.any !== (|eo)) begin
      nerr++;
      $display("FAIL %s out=%h/%h flag=%h/%h cnt=%h/%h any=%b (got/exp)",
        nm, bus.out, eo, bus.flag, ef, bus.cnt, ec, bus.any);
    end
  endtask

  task automatic check_val(string nm, int got, int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc(logic [3:0] i, logic [7:0] m,
                     logic c, logic r);
    rst      = r;
    bus.in   = i;
    bus.mode = m;
    bus.clr  = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  int pulses;

  initial begin
    for (int j = 0; j < 16; j++) begin
      tbl[j].in   = (j < 10) ? 4'h1 : 4'h0;
      tbl[j].mode = 8'h01;
      tbl[j].clr  = (j == 15);
      tbl[j].out  = (j == 3) ? 4'h1 : 4'h0;
      tbl[j].flag = (j >= 3 && j < 15) ? 4'h1 : 4'h0;
      tbl[j].cnt  = (j >= 3 && j < 15) ? 16'h1 : 16'h0;
    end

    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.in = '0;
    bus.mode = 8'hFF;
    bus.clr = 1'b0;
    bus0.in = '0;
    bus0.mode = 8'h01;
    bus0.clr = 1'b0;

    // reset and idle
    for (int k = 0; k < 3; k++) cyc(4'h0, 8'hFF, 1'b0, 1'b1);
    check_exp("reset", 4'h0, 4'h0, 16'h0);
    for (int k = 0; k < 20; k++) begin
      cyc(4'h0, 8'hFF, 1'b0, 1'b0);
      check_exp("idle", 4'h0, 4'h0, 16'h0);
    end

    // ch0 rise with filter latency, no pulse on fall
    for (int j = 0; j < 16; j++) begin
      cyc(tbl[j].in, tbl[j].mode, tbl[j].clr, 1'b0);
      check_exp($sformatf("tbl%0d", j), tbl[j].out,
                tbl[j].flag, tbl[j].cnt);
    end

    // ch1 glitch rejected, then both edges reported
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc((k < 2) ? 4'h2 : 4'h0, 8'h0C, 1'b0, 1'b0);
      pulses += int'(bus.out[1]);
    end
    check_val("glitch_pulses", pulses, 0);
    check_val("glitch_cnt1", int'(bus.cnt[7:4]), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      cyc((k < 3) ? 4'h2 : 4'h0, 8'h0C, 1'b0, 1'b0);
      pulses += int'(bus.out[1]);
      if (k == 3) check_val("rise_pulse", int'(bus.out[1]), 1);
      if (k == 6) check_val("fall_pulse", int'(bus.out[1]), 1);
    end
    check_val("both_pulses", pulses, 2);
    check_val("both_cnt1", int'(bus.cnt[7:4]), 2);

    // ch2 counter saturation
    for (int e = 0; e < 20; e++)
      for (int k = 0; k < 8; k++)
        cyc((k < 4) ? 4'h4 : 4'h0, 8'h10, 1'b0, 1'b0);
    check_val("sat_cnt2", int'(bus.cnt[11:8]), 15);
    check_val("sat_flag2", int'(bus.flag[2]), 1);

    // clr alone, then clr coinciding with a ch3 fall accept
    cyc(4'h0, 8'h80, 1'b1, 1'b0);
    check_exp("clr_alone", 4'h0, 4'h0, 16'h0);
    for (int k = 0; k < 5; k++) cyc(4'h8, 8'h80, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(4'h0, 8'h80, 1'b0, 1'b0);
    check_val("pre_cnt3", int'(bus.cnt[15:12]), 1);
    for (int k = 0; k < 5; k++) cyc(4'h8, 8'h80, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      cyc(4'h0, 8'h80, (k == 3), 1'b0);
    check_exp("clr_event", 4'h8, 4'h8, 16'h1000);
    cyc(4'h0, 8'h00, 1'b1, 1'b0);

    // reset mid-filter
    cyc(4'h1, 8'h01, 1'b0, 1'b0);
    cyc(4'h1, 8'h01, 1'b0, 1'b0);
    cyc(4'h0, 8'h01, 1'b0, 1'b1);
    check_exp("rst_mid", 4'h0, 4'h0, 16'h0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(4'h0, 8'h01, 1'b0, 1'b0);
      pulses += int'(bus.out[0]);
    end
    check_val("rst_mid_pulses", pulses, 0);
    check_exp("rst_mid_after", 4'h0, 4'h0, 16'h0);

    // FILT=0 instance accepts one edge after the sample
    bus0.in = 4'h1;
    cyc(4'h0, 8'h00, 1'b0, 1'b0);
    check_val("f0_edge_k", int'(bus0.out[0]), 0);
    cyc(4'h0, 8'h00, 1'b0, 1'b0);
    check_val("f0_edge_k1", int'(bus0.out[0]), 1);
    cyc(4'h0, 8'h00, 1'b0, 1'b0);
    check_val("f0_edge_k2", int'(bus0.out[0]), 0);
    check_val("f0_cnt0", int'(bus0.cnt[3:0]), 1);
    bus0.in = 4'h0;

    // random traffic against the model
    begin
      logic [3:0] ri;
      logic [7:0] rm;
      ri = 4'h0;
      rm = 8'hFF;
      for (int k = 0; k < 600; k++) begin
        for (int b = 0; b < CH; b++)
          if ($urandom_range(0, 3) == 0) ri[b] = ~ri[b];
        if ($urandom_range(0, 15) == 0)
          rm = 8'($urandom_range(0, 255));
        cyc(ri, rm, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 99) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
